brent_kung_pipe: RTL

BRENT_KUNG_PIPE -- requirements
Module: brent_kung_pipe

---
 rtl/brent_kung_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/brent_kung_pipe.sv
// rtl/brent_kung_pipe.sv - pipelined Brent-Kung adder/subtractor with valid/ready flow control
// Up to three register slots: after g/p generation, after the up-sweep, and at the output.
module brent_kung_pipe #(
  parameter int WIDTH  = 12,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] INPUTS,
  input  logic               cin,
  input  logic               sub,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH:0]     OUTS,
  output logic               ovf,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int L = $clog2(WIDTH);
  localparam int N = 1 << L;

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("brent_kung_pipe: STAGES must be in 1..3");
  end
  if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("brent_kung_pipe: WIDTH must be in 4..64");
  end

  // Tree operands padded to a power of two; pad lanes hold g=0, p=0.
  typedef struct packed {
    logic [N-1:0]     g;
    logic [N-1:0]     p;
    logic [WIDTH-1:0] hp;
    logic             c0;
  } gp_t;

  function automatic gp_t gp_gen(input logic [2*WIDTH-1:0] ops, input logic ci, input logic sb);
    gp_t r;
    logic bi;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bi      = ops[2*i+1] ^ sb;
      r.g[i]  = ops[2*i] & bi;
      r.p[i]  = ops[2*i] ^ bi;
      r.hp[i] = ops[2*i] ^ bi;
    end
    r.c0 = sb | ci;
    return r;
  endfunction

  function automatic gp_t up_sweep(input gp_t x);
    gp_t r;
    int  h;
    int  j;
    r = x;
    for (int lv = 0; lv < L; lv++) begin
      h = 1 << lv;
      for (int i = 0; i < N; i++) begin
        if (i % (2*h) == 2*h - 1) begin
          j      = (i >= h) ? i - h : 0;
          r.g[i] = r.g[i] | (r.p[i] & r.g[j]);
          r.p[i] = r.p[i] & r.p[j];
        end
      end
    end
    return r;
  endfunction

  // Down-sweep fills the remaining prefixes, then cin folds in as a final g|p&c0 per bit.
  function automatic logic [WIDTH+1:0] down_sum(input gp_t x);
    gp_t            r;
    logic [WIDTH:0] c;
    int             h;
    int             j;
    r = x;
    for (int lv = L - 2; lv >= 0; lv--) begin
      h = 1 << lv;
      for (int i = 0; i < N; i++) begin
        if (i >= 3*h - 1 && i % (2*h) == h - 1) begin
          j      = (i >= h) ? i - h : 0;
          r.g[i] = r.g[i] | (r.p[i] & r.g[j]);
          r.p[i] = r.p[i] & r.p[j];
        end
      end
    end
    c[0] = r.c0;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = r.g[i] | (r.p[i] & r.c0);
    end
    return {c[WIDTH] ^ c[WIDTH-1], c[WIDTH], r.hp ^ c[WIDTH-1:0]};
  endfunction

  gp_t              gen_d, a_d, up_d, b_d;
  logic             a_v, b_v;
  logic             a_ready, b_ready, o_ready;
  logic [WIDTH+1:0] fin_d;

  assign gen_d   = gp_gen(INPUTS, cin, sub);
  assign o_ready = !out_valid | out_ready;

  if (STAGES >= 3) begin : g_reg_gp
    logic va;
    gp_t  q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       va <= 1'b0;
      else if (a_ready) va <= in_valid;
    end
    always_ff @(posedge clk) begin
      if (a_ready && in_valid) q <= gen_d;
    end
    assign a_ready = !va | b_ready;
    assign a_v     = va;
    assign a_d     = q;
  end else begin : g_pass_gp
    assign a_ready = b_ready;
    assign a_v     = in_valid;
    assign a_d     = gen_d;
  end

  assign up_d = up_sweep(a_d);

  if (STAGES >= 2) begin : g_reg_up
    logic vb;
    gp_t  q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       vb <= 1'b0;
      else if (b_ready) vb <= a_v;
    end
    always_ff @(posedge clk) begin
      if (b_ready && a_v) q <= up_d;
    end
    assign b_ready = !vb | o_ready;
    assign b_v     = vb;
    assign b_d     = q;
  end else begin : g_pass_up
    assign b_ready = o_ready;
    assign b_v     = a_v;
    assign b_d     = up_d;
  end

  assign fin_d = down_sum(b_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      OUTS      <= '0;
      ovf       <= 1'b0;
    end else if (o_ready) begin
      out_valid <= b_v;
      if (b_v) {ovf, OUTS} <= fin_d;
    end
  end

  assign in_ready = a_ready;
endmodule
